// File: rtl/mem_port_arbiter_if.sv
// Memory-port bundle shared between two requesters (A = CPU data path,
// B = debug/program loader) and the single 16-bit memory port.
// slave: the arbiter side. master: the requesters + memory side.
interface mem_port_arbiter_if;
    logic        a_req;
    logic [15:0] a_addr;
    logic [15:0] a_wdata;
    logic        a_we;
    logic        a_gnt;
    logic [15:0] a_rdata;
    logic        a_rvalid;

    logic        b_req;
    logic [15:0] b_addr;
    logic [15:0] b_wdata;
    logic        b_we;
    logic        b_gnt;
    logic [15:0] b_rdata;
    logic        b_rvalid;

    logic [15:0] mem_access_addr;
    logic [15:0] mem_write_data;
    logic        mem_write_en;
    logic [15:0] mem_read_data;

    modport slave (
        input  a_req, a_addr, a_wdata, a_we,
        output a_gnt, a_rdata, a_rvalid,
        input  b_req, b_addr, b_wdata, b_we,
        output b_gnt, b_rdata, b_rvalid,
        output mem_access_addr, mem_write_data, mem_write_en,
        input  mem_read_data
    );

    modport master (
        output a_req, a_addr, a_wdata, a_we,
        input  a_gnt, a_rdata, a_rvalid,
        output b_req, b_addr, b_wdata, b_we,
        input  b_gnt, b_rdata, b_rvalid,
        input  mem_access_addr, mem_write_data, mem_write_en,
        output mem_read_data
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester round-robin arbiter for a single 16-bit memory port with
// bounded bursts: the current owner keeps the port for up to MAX_BURST
// back-to-back grants while the other requester waits. Read data returns
// registered one cycle after the grant.
// Optional statistics counters: define MEM_ARB_STATS_EN.
module mem_port_arbiter #(
    parameter int MAX_BURST = 4,   // 1..15
    parameter int STAT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_port_arbiter_if.slave     bus
`ifdef MEM_ARB_STATS_EN
    ,
    input  logic                  stat_clr,
    output logic [STAT_W-1:0]     stat_a_grants,
    output logic [STAT_W-1:0]     stat_b_grants,
    output logic [STAT_W-1:0]     stat_stall_cycles
`endif
);
    localparam logic [3:0] MAX_B = MAX_BURST[3:0];

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} owner_e;

    owner_e      owner_q, owner_d;
    logic        last_b_q, last_b_d;   // 1: B was granted last
    logic [3:0]  burst_q, burst_d;
    logic        a_gnt, b_gnt;
    logic [15:0] a_rdata_q, b_rdata_q;
    logic        a_rvalid_q, b_rvalid_q;

    // Grant decision: a lone requester always wins; under contention the
    // owner keeps the port until its burst is spent, then the one not
    // granted last wins. Nothing is granted during reset.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            if (bus.a_req && bus.b_req) begin
                if (owner_q == OWN_A && burst_q < MAX_B)      a_gnt = 1'b1;
                else if (owner_q == OWN_B && burst_q < MAX_B) b_gnt = 1'b1;
                else if (last_b_q)                            a_gnt = 1'b1;
                else                                          b_gnt = 1'b1;
            end else begin
                a_gnt = bus.a_req;
                b_gnt = bus.b_req;
            end
        end
    end

    // Next owner / burst length / last-granted bookkeeping.
    always_comb begin
        owner_d  = IDLE;
        burst_d  = 4'd0;
        last_b_d = last_b_q;
        if (a_gnt) begin
            owner_d  = OWN_A;
            burst_d  = (owner_q != OWN_A) ? 4'd1 :
                       (burst_q >= MAX_B) ? MAX_B : burst_q + 4'd1;
            last_b_d = 1'b0;
        end else if (b_gnt) begin
            owner_d  = OWN_B;
            burst_d  = (owner_q != OWN_B) ? 4'd1 :
                       (burst_q >= MAX_B) ? MAX_B : burst_q + 4'd1;
            last_b_d = 1'b1;
        end
    end

    // Arbitration state and registered read return.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q    <= IDLE;
            last_b_q   <= 1'b1;
            burst_q    <= 4'd0;
            a_rdata_q  <= 16'd0;
            b_rdata_q  <= 16'd0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            last_b_q   <= last_b_d;
            burst_q    <= burst_d;
            a_rvalid_q <= a_gnt && !bus.a_we;
            b_rvalid_q <= b_gnt && !bus.b_we;
            if (a_gnt && !bus.a_we) a_rdata_q <= bus.mem_read_data;
            if (b_gnt && !bus.b_we) b_rdata_q <= bus.mem_read_data;
        end
    end

    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign bus.a_rvalid = a_rvalid_q;
    assign bus.b_rvalid = b_rvalid_q;

    // Granted requester drives the port; idle port is all zeros.
    assign bus.mem_access_addr = a_gnt ? bus.a_addr  : b_gnt ? bus.b_addr  : 16'd0;
    assign bus.mem_write_data  = a_gnt ? bus.a_wdata : b_gnt ? bus.b_wdata : 16'd0;
    assign bus.mem_write_en    = (a_gnt && bus.a_we) || (b_gnt && bus.b_we);

`ifdef MEM_ARB_STATS_EN
    logic [STAT_W-1:0] sa_q, sb_q, ss_q;
    logic              stall;

    assign stall = (bus.a_req && !a_gnt) || (bus.b_req && !b_gnt);

    // Saturating grant / stall counters; clear beats increment.
    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            sa_q <= '0;
            sb_q <= '0;
            ss_q <= '0;
        end else begin
            if (a_gnt && sa_q != '1) sa_q <= sa_q + 1'b1;
            if (b_gnt && sb_q != '1) sb_q <= sb_q + 1'b1;
            if (stall && ss_q != '1) ss_q <= ss_q + 1'b1;
        end
    end

    assign stat_a_grants     = sa_q;
    assign stat_b_grants     = sb_q;
    assign stat_stall_cycles = ss_q;
`endif
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by a randomized
// phase, all compared every cycle against a streak-based reference model.
module tb_mem_port_arbiter;
    localparam int MAXB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if ifc ();

    logic [15:0] mem [0:65535];
    assign ifc.mem_read_data = mem[ifc.mem_access_addr];

`ifdef MEM_ARB_STATS_EN
    logic        stat_clr = 1'b0;
    logic [15:0] stat_a_grants, stat_b_grants, stat_stall_cycles;
    int          m_sa = 0, m_sb = 0, m_ss = 0;
    mem_port_arbiter #(.MAX_BURST(MAXB), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(ifc), .stat_clr(stat_clr),
        .stat_a_grants(stat_a_grants), .stat_b_grants(stat_b_grants),
        .stat_stall_cycles(stat_stall_cycles));
`else
    mem_port_arbiter #(.MAX_BURST(MAXB), .STAT_W(16)) dut (
        .clk(clk), .rst(rst), .bus(ifc));
`endif

    int nchk = 0, nerr = 0;

    // Reference model: who was granted in the previous cycle (-1 none),
    // how many consecutive cycles they have been granted, who was last.
    int          prev_g = -1, run = 0, last_g = 1, g_cur = -1;
    bit          e_rv_a = 0, e_rv_b = 0;
    logic [15:0] e_rd_a = 0, e_rd_b = 0;
    int          a_grants_seen = 0, b_grants_seen = 0;

    // Current stimulus values.
    bit          ar = 0, awe = 0, br = 0, bwe = 0;
    logic [15:0] aa = 0, aw = 0, ba = 0, bw = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check combinational + registered outputs, then
    // advance the model and the memory contents.
    task automatic cyc(input bit r);
        int          g;
        logic [15:0] ex_addr, ex_wd;
        bit          ex_we;
        @(negedge clk);
        rst = r;
        ifc.a_req = ar; ifc.a_addr = aa; ifc.a_wdata = aw; ifc.a_we = awe;
        ifc.b_req = br; ifc.b_addr = ba; ifc.b_wdata = bw; ifc.b_we = bwe;
        #1;
        if (r)              g = -1;
        else if (ar && !br) g = 0;
        else if (br && !ar) g = 1;
        else if (ar && br)  g = (prev_g >= 0 && run < MAXB) ? prev_g : 1 - last_g;
        else                g = -1;
        ex_addr = (g == 0) ? aa  : (g == 1) ? ba  : 16'd0;
        ex_wd   = (g == 0) ? aw  : (g == 1) ? bw  : 16'd0;
        ex_we   = (g == 0) ? awe : (g == 1) ? bwe : 1'b0;

        chk("a_gnt",    32'(ifc.a_gnt), 32'(g == 0));
        chk("b_gnt",    32'(ifc.b_gnt), 32'(g == 1));
        chk("mem_addr", 32'(ifc.mem_access_addr), 32'(ex_addr));
        chk("mem_wdata",32'(ifc.mem_write_data),  32'(ex_wd));
        chk("mem_we",   32'(ifc.mem_write_en),    32'(ex_we));
        chk("a_rvalid", 32'(ifc.a_rvalid), 32'(e_rv_a));
        chk("b_rvalid", 32'(ifc.b_rvalid), 32'(e_rv_b));
        chk("a_rdata",  32'(ifc.a_rdata),  32'(e_rd_a));
        chk("b_rdata",  32'(ifc.b_rdata),  32'(e_rd_b));
`ifdef MEM_ARB_STATS_EN
        chk("stat_a", 32'(stat_a_grants),     32'(m_sa));
        chk("stat_b", 32'(stat_b_grants),     32'(m_sb));
        chk("stat_s", 32'(stat_stall_cycles), 32'(m_ss));
        if (r || stat_clr) begin
            m_sa = 0; m_sb = 0; m_ss = 0;
        end else begin
            if (g == 0 && m_sa < 65535) m_sa++;
            if (g == 1 && m_sb < 65535) m_sb++;
            if (((ar && g != 0) || (br && g != 1)) && m_ss < 65535) m_ss++;
        end
`endif
        if (r) begin
            prev_g = -1; run = 0; last_g = 1;
            e_rv_a = 0; e_rv_b = 0; e_rd_a = 0; e_rd_b = 0;
        end else begin
            e_rv_a = (g == 0) && !awe;
            e_rv_b = (g == 1) && !bwe;
            if (e_rv_a) e_rd_a = mem[aa];
            if (e_rv_b) e_rd_b = mem[ba];
            if (g >= 0) begin
                run    = (g == prev_g) ? run + 1 : 1;
                prev_g = g;
                last_g = g;
                if (ex_we) mem[ex_addr] = ex_wd;
            end else begin
                prev_g = -1; run = 0;
            end
        end
        if (g == 0) a_grants_seen++;
        if (g == 1) b_grants_seen++;
        g_cur = g;
    endtask

    task automatic idle();
        ar = 0; br = 0; awe = 0; bwe = 0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        mem[16'h0010] = 16'h1234;
        ifc.a_req = 0; ifc.a_addr = 0; ifc.a_wdata = 0; ifc.a_we = 0;
        ifc.b_req = 0; ifc.b_addr = 0; ifc.b_wdata = 0; ifc.b_we = 0;
        @(posedge clk);
        cyc(1); cyc(1);
        cyc(0);

        // A reads 0x0010, then the registered return.
        ar = 1; aa = 16'h0010; awe = 0;
        cyc(0);
        idle(); cyc(0);
        chk("a_read_0010", 32'(ifc.a_rdata), 32'h1234);

        // B writes 0x00AA to 0x0020; A reads it back.
        br = 1; ba = 16'h0020; bw = 16'h00AA; bwe = 1;
        cyc(0);
        idle(); ar = 1; aa = 16'h0020;
        cyc(0);
        idle(); cyc(0);
        chk("a_read_0020", 32'(ifc.a_rdata), 32'h00AA);

        // 12 cycles of contention from reset: A x4, B x4, A x4.
        cyc(1);
        a_grants_seen = 0; b_grants_seen = 0;
        ar = 1; aa = 16'h0100; awe = 0; br = 1; ba = 16'h0200; bwe = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(0);
            chk("burst_pattern", 32'(g_cur), 32'((i / 4) % 2));
        end
        chk("contend_a_total", 32'(a_grants_seen), 32'd8);
        chk("contend_b_total", 32'(b_grants_seen), 32'd4);

        // Both from reset: A first, A drops after 2 grants, B follows.
        idle(); cyc(1);
        ar = 1; br = 1; bwe = 0; awe = 0;
        cyc(0); chk("from_reset_1", 32'(g_cur), 32'd0);
        cyc(0); chk("from_reset_2", 32'(g_cur), 32'd0);
        ar = 0;
        cyc(0); chk("after_drop", 32'(g_cur), 32'd1);

        // Reset while A requests a read: no grant, no rvalid afterwards.
        idle(); ar = 1; aa = 16'h0010;
        cyc(0);
        cyc(1);
        idle(); cyc(0);
        chk("rvalid_after_rst", 32'(ifc.a_rvalid), 32'd0);
        ar = 1; br = 1;
        cyc(0); chk("post_rst_contend", 32'(g_cur), 32'd0);

`ifdef MEM_ARB_STATS_EN
        idle(); cyc(1);
        ar = 1; br = 1;
        for (int i = 0; i < 6; i++) cyc(0);
        idle(); cyc(0);
        chk("stat_a_6", 32'(stat_a_grants), 32'd4);
        chk("stat_b_6", 32'(stat_b_grants), 32'd2);
        chk("stat_s_6", 32'(stat_stall_cycles), 32'd6);
        stat_clr = 1; cyc(0); stat_clr = 0;
        cyc(0);
        chk("stat_clr", 32'(stat_a_grants | stat_b_grants | stat_stall_cycles), 32'd0);
`endif

        // Randomized traffic over a small address window; a pending
        // requester holds its request and payload until granted.
        for (int k = 0; k < 400; k++) begin
            bit r;
            r = ($urandom_range(0, 49) == 0);
            if (!(ar && g_cur != 0)) begin
                ar = ($urandom_range(0, 3) != 0);
                aa = 16'($urandom_range(0, 15)); aw = 16'($urandom); awe = $urandom_range(0, 1) == 1;
            end
            if (!(br && g_cur != 1)) begin
                br = ($urandom_range(0, 3) != 0);
                ba = 16'($urandom_range(0, 15)); bw = 16'($urandom); bwe = $urandom_range(0, 1) == 1;
            end
`ifdef MEM_ARB_STATS_EN
            stat_clr = ($urandom_range(0, 29) == 0);
`endif
            cyc(r);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
